signed_seq_divider: RTL and testbench
=====================================

# signed_seq_divider

Sequential signed divider that inverts the 8x8 -> 16 signed multiply: it divides a 16-bit two's-complement dividend (a multiplier product) by an 8-bit two's-complement divisor. It returns a 16-bit quotient and an 8-bit remainder using a start/busy/done handshake. It sits beside the signed multipliers in the arithmetic datapath, so that `(a*b)/b == a` is checkable in-system. The datapath is restoring, one quotient bit per clock, and uses no divide operator.

## Interface
- `N`, default 8: divisor width. The dividend and quotient are 2N bits; the remainder is N bits.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request. Sampled only in IDLE.
- `dividend`  in  2N: signed dividend. Captured on the accepting edge.
- `divisor`  in  N: signed divisor. Captured on the accepting edge.
- `busy`  out  1: high from the accepting edge until the result edge.
- `done`  out  1: one-cycle pulse. Results are valid while it is high and afterwards.
- `quotient`  out  2N: signed quotient, truncated toward zero.
- `remainder`  out  N: signed remainder. Its sign follows the dividend; it is 0 when exact.
- `div_by_zero`  out  1: set when the divisor is 0.
- `overflow`  out  1: set when the quotient is not representable (only -2^(2N-1) / -1).

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - If `start`=1, capture the operands.
  - Form `|dividend|` as a 2N-bit unsigned value; -32768 maps to 0x8000.
  - Form `|divisor|` as an (N+1)-bit value.
  - Record `q_neg = sign(dividend) ^ sign(divisor)` and `r_neg = sign(dividend)`.
  - Clear bit counter to 0 and the partial remainder to 0.
  - Set `busy`=1. Go to CALC, or to DONE directly when the divisor is 0.
- **CALC** (exactly 2N cycles), for each cycle:
  - Shift the partial remainder left by 1, bringing in the dividend MSB.
  - Trial-subtract `|divisor|`. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - The partial remainder is N+1 bits wide.
  - After the counter reaches 2N-1, go to FIX.
- **FIX** (1 cycle): apply signs and register the outputs.
  - `quotient = q_neg ? -Q : Q`.
  - `remainder = r_neg ? -R : R`.
  - If `q_neg`=0 and the magnitude Q = 2^(2N-1), then `quotient` = 0x7FFF, `overflow`=1, `remainder`=0.
  - Go to DONE.
- **Divide-by-zero path** (IDLE -> DONE): register `quotient`=0, `remainder=dividend[N-1:0]`, `div_by_zero`=1.
- **DONE** (1 cycle): `done`=1, `busy`=0. Return to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor restarted.
- `start` held high re-triggers only after returning to IDLE, so back-to-back ops are spaced at least 1 IDLE cycle apart.
- Outputs and flags hold their value until the next accepting edge. On that edge, both flags clear.

## Timing
- Reset (asynchronous, immediate) drives all outputs to 0 (`busy`, `done`, `quotient`, `remainder`, `div_by_zero`, `overflow`), forces state to IDLE, and clears the counter.
- Reset mid-operation aborts; no `done` pulse follows.
- Let E0 be the edge that accepts `start`.
- **Normal path:**
  - `busy` is high after E0.
  - CALC occupies E1..E16 and FIX is E17.
  - After E17, `done`=1 and the results are valid.
  - After E18, `done`=0 and the block is back in IDLE.
  - Latency is 17 clocks from E0 to results, with 1 clock of `done`.
- **Divide-by-zero:** results and `done` are valid after E1; `done` drops after E2.
- Operand inputs may change after E0 without effect.
- Throughput is one result per 19 clocks with `start` tied high (IDLE, E0..E17, DONE).

## Test plan
- 1000 / -7 -> `quotient`=0xFF72 (-142), `remainder`=0x06; `done` 17 clocks after the start edge; both flags 0.
- -1000 / 7 -> `quotient`=0xFF72, `remainder`=0xFA (-6). Then 16384 / -128 -> `quotient`=0xFF80, `remainder`=0 (the inverse of -128 * -128).
- -32768 / -1 -> `quotient`=0x7FFF, `remainder`=0, `overflow`=1. Then -32768 / 1 -> `quotient`=0x8000, `overflow`=0.
- 5 / 0 -> `div_by_zero`=1, `quotient`=0, `remainder`=0x05, `done` after E1. The next valid op clears the flag.
- Pulse `start` with new operands during CALC, then assert `rst_n`=0 at cycle 8 of a second op:
  - The mid-CALC start is ignored and the first result is unchanged.
  - The reset immediately zeroes all outputs and no `done` pulse appears.
- Random sweep of a, b in -128..127:
  - Divide `a*b` by b (b != 0) and check `quotient`=a sign-extended, `remainder`=0.
  - Also check random dividends against the truncating reference: `q*d + r == dividend` and `|r| < |d|`.

Source files
------------

// File: rtl/signed_seq_divider.sv
// signed_seq_divider
//   Restoring signed divider, one quotient bit per clock. Divides a 2N-bit
//   two's-complement dividend by an N-bit two's-complement divisor and returns
//   a 2N-bit quotient (truncated toward zero) and an N-bit remainder whose sign
//   follows the dividend. Sits beside the signed multipliers so that
//   (a*b)/b == a can be checked in-system.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : request, sampled only while idle
//   dividend     : 2N-bit signed dividend, captured on the accepting edge
//   divisor      : N-bit signed divisor, captured on the accepting edge
//   busy         : high from the accepting edge until the result edge
//   done         : one-cycle pulse; results valid while high and afterwards
//   quotient     : 2N-bit signed quotient
//   remainder    : N-bit signed remainder
//   div_by_zero  : divisor was 0
//   overflow     : quotient not representable (-2^(2N-1) / -1)
//   state_dbg    : current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: start is accepted on any rising edge where the block is idle
// (busy=0, done=0); busy then rises and stays high until the edge that makes
// done=1. done lasts exactly one cycle, after which the block is idle again.
// start seen while not idle is dropped, never queued. quotient/remainder and
// the flags hold until the next accepting edge, where the flags clear.

module signed_seq_divider #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(2 * N - 1);
    localparam logic [2*N-1:0] Q_MIN_MAG = {1'b1, {(2 * N - 1){1'b0}}};
    localparam logic [2*N-1:0] Q_MAX     = {1'b0, {(2 * N - 1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [N:0]      part_rem;   // partial remainder, N+1 bits
    logic [2*N-1:0]  shift_q;    // dividend magnitude shifts out the top, quotient bits shift in
    logic [N:0]      div_mag;    // |divisor|; needs N+1 bits for -2^(N-1)
    logic            q_neg;
    logic            r_neg;

    logic [2*N-1:0]  dvd_mag;
    logic [N:0]      dvs_ext;
    logic [N:0]      dvs_mag;
    logic [N:0]      shifted;
    logic [N+1:0]    trial;
    logic [2*N-1:0]  q_signed;
    logic [N-1:0]    r_signed;

    always_comb begin
        // Unary minus wraps, so the most negative dividend maps to 2^(2N-1).
        dvd_mag  = dividend[2*N-1] ? -dividend : dividend;
        dvs_ext  = {divisor[N-1], divisor};
        dvs_mag  = dvs_ext[N] ? -dvs_ext : dvs_ext;
        shifted  = {part_rem[N-1:0], shift_q[2*N-1]};
        // One extra bit on the left: its value is the borrow of the trial subtract.
        trial    = {1'b0, shifted} - {1'b0, div_mag};
        q_signed = q_neg ? -shift_q : shift_q;
        r_signed = r_neg ? -part_rem[N-1:0] : part_rem[N-1:0];
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            part_rem    <= '0;
            shift_q     <= '0;
            div_mag     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shift_q     <= dvd_mag;
                        div_mag     <= dvs_mag;
                        q_neg       <= dividend[2*N-1] ^ divisor[N-1];
                        r_neg       <= dividend[2*N-1];
                        bit_cnt     <= '0;
                        part_rem    <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor skips the datapath; results are known now.
                            quotient    <= '0;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (!trial[N+1]) begin
                        part_rem <= trial[N:0];
                        shift_q  <= {shift_q[2*N-2:0], 1'b1};
                    end else begin
                        part_rem <= shifted;
                        shift_q  <= {shift_q[2*N-2:0], 1'b0};
                    end
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    // A positive quotient of magnitude 2^(2N-1) only arises from
                    // the most negative dividend over -1; saturate and flag it.
                    if (!q_neg && shift_q == Q_MIN_MAG) begin
                        quotient  <= Q_MAX;
                        remainder <= '0;
                        overflow  <= 1'b1;
                    end else begin
                        quotient  <= q_signed;
                        remainder <= r_signed;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end

                S_DONE: begin
                    // Arriving from FIX, done is already high: finish the pulse.
                    // Arriving straight from IDLE (zero divisor), raise it now.
                    if (done) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider
//   Directed bench for signed_seq_divider (N=8). Expected results come from a
//   behavioural model using plain integer division; a compare process checks
//   busy/done and every result against it, and the main sequence adds
//   hand-computed literal expectations.

module tb_signed_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;
    logic [1:0]  state_dbg;

    int total;
    int bad;
    int cycle;
    int acc_cycle;
    int last_lat;

    logic [15:0] exp_q[$];
    logic [7:0]  exp_r[$];
    logic [1:0]  exp_f[$];   // {div_by_zero, overflow}
    int          exp_lat[$];
    int          acc_q[$];

    signed_seq_divider #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Truncating signed division from the arithmetic definition.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic [1:0] f, output int lat);
        int ai;
        int bi;
        int qi;
        int ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = '0; r = a[7:0]; f = 2'b10; lat = 1;
        end else if (ai == -32768 && bi == -1) begin
            q = 16'h7FFF; r = '0; f = 2'b01; lat = 17;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q = qi[15:0]; r = ri[7:0]; f = 2'b00; lat = 17;
        end
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic flush_exp();
        exp_q.delete(); exp_r.delete(); exp_f.delete();
        exp_lat.delete(); acc_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] q;
        logic [7:0]  r;
        logic [1:0]  f;
        int          lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        acc_cycle = cycle;
        model(a, b, q, r, f, lat);
        exp_q.push_back(q); exp_r.push_back(r); exp_f.push_back(f);
        exp_lat.push_back(lat); acc_q.push_back(acc_cycle);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            chk("done_timeout", 0, 1);
            flush_exp();
            last_lat = -1;
        end else begin
            last_lat = cycle - acc_cycle;
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [7:0] b);
        start_op(a, b);
        wait_done();
    endtask

    // ---------------- scoreboard / compare ----------------
    logic prev_done;
    initial prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_one_cycle", int'(prev_done), 0);
                chk("busy_at_done", int'(busy), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("quotient", int'(quotient), int'(exp_q.pop_front()));
                    chk("remainder", int'(remainder), int'(exp_r.pop_front()));
                    chk("flags", int'({div_by_zero, overflow}), int'(exp_f.pop_front()));
                    chk("latency", cycle - acc_q.pop_front(), exp_lat.pop_front());
                end
            end else begin
                chk("busy", int'(busy), int'(exp_q.size() != 0));
            end
            prev_done = done;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] mq;
        logic [7:0]  mr;
        logic [1:0]  mf;
        int          ml;
        int          done_cnt;

        total = 0;
        bad   = 0;
        last_lat = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Pin the model with hand-computed values.
        model(16'd1000, 8'hF9, mq, mr, mf, ml);
        chk("pin_q_1000_m7", int'(mq), 'hFF72);
        chk("pin_r_1000_m7", int'(mr), 'h06);
        model(16'hFC18, 8'h07, mq, mr, mf, ml);
        chk("pin_q_m1000_7", int'(mq), 'hFF72);
        chk("pin_r_m1000_7", int'(mr), 'hFA);
        model(16'h8000, 8'hFF, mq, mr, mf, ml);
        chk("pin_q_ovf", int'(mq), 'h7FFF);
        chk("pin_f_ovf", int'(mf), 1);
        model(16'd5, 8'h00, mq, mr, mf, ml);
        chk("pin_r_dz", int'(mr), 5);
        chk("pin_lat_dz", ml, 1);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dz", int'(div_by_zero), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_state", int'(state_dbg), 0);
        rst_n = 1'b1;

        // 1000 / -7
        run_op(16'd1000, 8'hF9);
        chk("q_1000_m7", int'(quotient), 'hFF72);
        chk("r_1000_m7", int'(remainder), 'h06);
        chk("f_1000_m7", int'({div_by_zero, overflow}), 0);
        chk("lat_1000_m7", last_lat, 17);

        // -1000 / 7
        run_op(16'hFC18, 8'h07);
        chk("q_m1000_7", int'(quotient), 'hFF72);
        chk("r_m1000_7", int'(remainder), 'hFA);

        // 16384 / -128
        run_op(16'h4000, 8'h80);
        chk("q_16384_m128", int'(quotient), 'hFF80);
        chk("r_16384_m128", int'(remainder), 0);

        // -32768 / -1 overflows; -32768 / 1 does not.
        run_op(16'h8000, 8'hFF);
        chk("q_ovf", int'(quotient), 'h7FFF);
        chk("r_ovf", int'(remainder), 0);
        chk("ovf_set", int'(overflow), 1);
        run_op(16'h8000, 8'h01);
        chk("q_min_1", int'(quotient), 'h8000);
        chk("ovf_clr", int'(overflow), 0);

        // 5 / 0
        run_op(16'd5, 8'h00);
        chk("dz_set", int'(div_by_zero), 1);
        chk("q_dz", int'(quotient), 0);
        chk("r_dz", int'(remainder), 5);
        chk("lat_dz", last_lat, 1);

        // Next valid op clears the flag on its accepting edge.
        start_op(16'd100, 8'd3);
        chk("dz_clear_on_accept", int'(div_by_zero), 0);
        wait_done();
        chk("q_100_3", int'(quotient), 33);
        chk("r_100_3", int'(remainder), 1);

        // start pulsed mid-CALC with new operands is ignored.
        start_op(16'hB1E0, 8'd9);   // -20000 / 9
        repeat (5) @(negedge clk);
        dividend = 16'd7;
        divisor  = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done();
        chk("q_mid_start", int'(quotient), 'hF752);
        chk("r_mid_start", int'(remainder), 'hFE);
        repeat (25) @(negedge clk);
        chk("q_hold", int'(quotient), 'hF752);

        // Reset at cycle 8 of an operation aborts it.
        start_op(16'd12345, 8'd11);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        flush_exp();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_flags", int'({div_by_zero, overflow}), 0);
        chk("abort_state", int'(state_dbg), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("no_done_after_abort", done_cnt, 0);

        // (a*b)/b == a.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            int         p;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            p = int'($signed(a)) * int'($signed(b));
            run_op(p[15:0], b);
            chk("inv_q", int'(quotient), int'({{8{a[7]}}, a}));
            chk("inv_r", int'(remainder), 0);
        end

        // Random dividends: q*d + r == dividend and |r| < |d|.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] dd;
            logic [7:0]  dv;
            int          qi;
            int          ri;
            int          di;
            dd = 16'($urandom_range(0, 65535));
            dv = 8'($urandom_range(1, 255));
            if (dd == 16'h8000 && dv == 8'hFF) dv = 8'h03;
            run_op(dd, dv);
            qi = int'($signed(quotient));
            ri = int'($signed(remainder));
            di = int'($signed(dv));
            chk("ident", qi * di + ri, int'($signed(dd)));
            chk("rem_mag", int'(iabs(ri) < iabs(di)), 1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
